// File: rtl/pid_error_history_if.sv
// Handshake bundle for the PID error-history stage: sample input
// (valid/ready/err) and difference-term output (valid/ready/e/d1/d2/flags).
// The slave modport is the block's view; master is the producer/consumer view.
interface pid_error_history_if #(
  parameter int W = 16
);
  logic                in_valid;
  logic                in_ready;
  logic signed [W-1:0] in_err;
  logic                out_valid;
  logic                out_ready;
  logic signed [W-1:0] out_e;
  logic signed [W-1:0] out_d1;
  logic signed [W-1:0] out_d2;
  logic                out_warm;
  logic                out_sat;

  modport master (
    output in_valid, in_err, out_ready,
    input  in_ready, out_valid, out_e, out_d1, out_d2, out_warm, out_sat
  );

  modport slave (
    input  in_valid, in_err, out_ready,
    output in_ready, out_valid, out_e, out_d1, out_d2, out_warm, out_sat
  );
endinterface

// File: rtl/pid_error_history.sv
// pid_error_history: keeps e[n-1], e[n-2] and emits registered incremental
// PID terms e[n], e[n]-e[n-1], e[n]-2e[n-1]+e[n-2] through a one-entry output
// register. Optional build macro PID_ERR_SATURATE_EN clamps d1/d2 to W bits
// and flags the clip on out_sat; without it d1/d2 wrap and out_sat is 0.
module pid_error_history #(
  parameter int W = 16
) (
  input logic             clk,
  input logic             reset,   // synchronous, active low
  input logic             clear,   // synchronous history flush
  pid_error_history_if.slave bus
);

  localparam int WX = W + 2;

  typedef enum logic [1:0] {
    FILL0 = 2'd0,
    FILL1 = 2'd1,
    RUN   = 2'd2
  } state_t;

  state_t              r_state;
  logic signed [W-1:0] r_h1;
  logic signed [W-1:0] r_h2;
  logic signed [W-1:0] r_e;
  logic signed [W-1:0] r_d1;
  logic signed [W-1:0] r_d2;
  logic                r_valid;
  logic                r_warm;
  logic                r_sat;

  logic                 w_in_ready;
  logic                 w_accept;
  logic signed [WX-1:0] w_ex;
  logic signed [WX-1:0] w_h1x;
  logic signed [WX-1:0] w_h2x;
  logic signed [WX-1:0] w_d1_full;
  logic signed [WX-1:0] w_d2_full;
  logic signed [W-1:0]  w_d1_red;
  logic signed [W-1:0]  w_d2_red;
  logic                 w_sat;

  // A new sample fits whenever the output slot is empty or being drained now.
  assign w_in_ready = reset & ~clear & (~r_valid | bus.out_ready);
  assign w_accept   = bus.in_valid & w_in_ready;

  // Full-precision differences; W+2 bits cannot overflow for any inputs.
  assign w_ex      = {{2{bus.in_err[W-1]}}, bus.in_err};
  assign w_h1x     = {{2{r_h1[W-1]}}, r_h1};
  assign w_h2x     = {{2{r_h2[W-1]}}, r_h2};
  assign w_d1_full = w_ex - w_h1x;
  assign w_d2_full = w_ex - (w_h1x <<< 1) + w_h2x;

`ifdef PID_ERR_SATURATE_EN
  localparam logic signed [WX-1:0] C_MAX = {3'b000, {(W-1){1'b1}}};
  localparam logic signed [WX-1:0] C_MIN = {3'b111, {(W-1){1'b0}}};

  // Returns {clipped, value}: the W-bit clamp of a W+2-bit difference.
  function automatic logic [W:0] sat_reduce(input logic signed [WX-1:0] v);
    logic [W:0] res;
    if (v > C_MAX) begin
      res = {1'b1, C_MAX[W-1:0]};
    end else if (v < C_MIN) begin
      res = {1'b1, C_MIN[W-1:0]};
    end else begin
      res = {1'b0, v[W-1:0]};
    end
    return res;
  endfunction

  logic w_d1_clip;
  logic w_d2_clip;
  assign {w_d1_clip, w_d1_red} = sat_reduce(w_d1_full);
  assign {w_d2_clip, w_d2_red} = sat_reduce(w_d2_full);
  assign w_sat = w_d1_clip | w_d2_clip;
`else
  // Two's-complement wrap: the guard bits are intentionally dropped.
  logic w_unused_hi;
  assign w_d1_red    = w_d1_full[W-1:0];
  assign w_d2_red    = w_d2_full[W-1:0];
  assign w_sat       = 1'b0;
  assign w_unused_hi = ^{w_d1_full[WX-1:W], w_d2_full[WX-1:W]};
`endif

  // History, fill state and output register; reset beats clear beats accept.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state <= FILL0;
      r_h1    <= '0;
      r_h2    <= '0;
      r_e     <= '0;
      r_d1    <= '0;
      r_d2    <= '0;
      r_valid <= 1'b0;
      r_warm  <= 1'b0;
      r_sat   <= 1'b0;
    end else if (clear) begin
      // Data registers keep their last values; only the pending flag drops.
      r_state <= FILL0;
      r_h1    <= '0;
      r_h2    <= '0;
      r_valid <= 1'b0;
    end else if (w_accept) begin
      r_e     <= bus.in_err;
      r_d1    <= w_d1_red;
      r_d2    <= w_d2_red;
      r_sat   <= w_sat;
      r_warm  <= (r_state == RUN);
      r_h2    <= r_h1;
      r_h1    <= bus.in_err;
      r_valid <= 1'b1;
      case (r_state)
        FILL0:   r_state <= FILL1;
        FILL1:   r_state <= RUN;
        RUN:     r_state <= RUN;
        default: r_state <= FILL0;
      endcase
    end else if (r_valid && bus.out_ready) begin
      r_valid <= 1'b0;
    end else begin
      r_valid <= r_valid;
    end
  end

  assign bus.in_ready  = w_in_ready;
  assign bus.out_valid = r_valid;
  assign bus.out_e     = r_e;
  assign bus.out_d1    = r_d1;
  assign bus.out_d2    = r_d2;
  assign bus.out_warm  = r_warm;
  assign bus.out_sat   = r_sat;

endmodule
